// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// Multiply uses shift-add and divide uses restoring shift-subtract, both on magnitudes, one bit per cycle.
module mult_div_unit #(
  parameter int unsigned WSIZE = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WSIZE-1:0] rs_val,
  input  logic [WSIZE-1:0] rt_val,
  output logic [WSIZE-1:0] hi,
  output logic [WSIZE-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WSIZE) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_lo;
  logic               neg_hi;
  logic               div_zero;
  logic [WSIZE-1:0]   a_q;
  logic [WSIZE-1:0]   rs_q;
  logic [2*WSIZE-1:0] acc;

  logic               rs_neg, rt_neg;
  logic [WSIZE-1:0]   rs_mag, rt_mag;
  logic [WSIZE:0]     mul_sum;
  logic [WSIZE:0]     rem_sh;
  logic [WSIZE:0]     diff;
  logic [2*WSIZE-1:0] step_next;
  logic [2*WSIZE-1:0] prod;
  logic [WSIZE-1:0]   quo, rem;
  logic [WSIZE-1:0]   res_hi, res_lo;

  always_comb begin
    rs_neg = ~op[0] & rs_val[WSIZE-1];
    rt_neg = ~op[0] & rt_val[WSIZE-1];
    rs_mag = rs_neg ? -rs_val : rs_val;
    rt_mag = rt_neg ? -rt_val : rt_val;

    // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient bits}
    mul_sum = {1'b0, acc[2*WSIZE-1:WSIZE]} + (acc[0] ? {1'b0, a_q} : '0);
    rem_sh  = {acc[2*WSIZE-1:WSIZE], acc[WSIZE-1]};
    diff    = rem_sh - {1'b0, a_q};
    if (!is_div)
      step_next = {mul_sum, acc[WSIZE-1:1]};
    else if (diff[WSIZE])
      step_next = {rem_sh[WSIZE-1:0], acc[WSIZE-2:0], 1'b0};
    else
      step_next = {diff[WSIZE-1:0], acc[WSIZE-2:0], 1'b1};

    prod = neg_lo ? -acc : acc;
    quo  = acc[WSIZE-1:0];
    rem  = acc[2*WSIZE-1:WSIZE];
    if (!is_div) begin
      res_hi = prod[2*WSIZE-1:WSIZE];
      res_lo = prod[WSIZE-1:0];
    end else if (div_zero) begin
      res_hi = rs_q;
      res_lo = '1;
    end else begin
      res_hi = neg_hi ? -rem : rem;
      res_lo = neg_lo ? -quo : quo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      a_q      <= '0;
      rs_q     <= '0;
      acc      <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                is_div   <= op[1];
                neg_lo   <= rs_neg ^ rt_neg;
                neg_hi   <= rs_neg;
                div_zero <= (rt_val == '0);
                rs_q     <= rs_val;
                a_q      <= op[1] ? rt_mag : rs_mag;
                acc      <= {{WSIZE{1'b0}}, (op[1] ? rs_mag : rt_mag)};
                cnt      <= '0;
                busy     <= 1'b1;
                state    <= CALC;
              end
              OP_MTHI: hi <= rs_val;
              OP_MTLO: lo <= rs_val;
              default: ;
            endcase
          end
        end
        CALC: begin
          acc <= step_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WSIZE - 1))
            state <= FINISH;
        end
        FINISH: begin
          hi    <= res_hi;
          lo    <= res_lo;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed results, latency, busy/done timing, reset and ignored requests.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic [31:0] hi, lo;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.WSIZE(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives a one-cycle request starting at the current negedge.
  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0; op = 3'b111; rs_val = 32'h5A5A_A5A5; rt_val = 32'h0F0F_F0F0;
  endtask

  // Returns at the negedge of the done cycle.
  task automatic wait_done(input string tag, input int exp_busy, input logic [31:0] eh, input logic [31:0] el);
    int n, nb;
    logic [31:0] h0, l0;
    bit moved;
    n = 0; nb = 0; moved = 0; h0 = hi; l0 = lo;
    while (done !== 1'b1 && n < 100) begin
      if (busy === 1'b1) nb++;
      if (hi !== h0 || lo !== l0) moved = 1;
      n++;
      @(negedge clk);
    end
    chk({tag, " done"}, {63'd0, done}, 64'd1);
    chk({tag, " busy_at_done"}, {63'd0, busy}, 64'd0);
    chk({tag, " busy_cycles"}, 64'(nb), 64'(exp_busy));
    chk({tag, " hilo_held"}, {63'd0, moved}, 64'd0);
    chk({tag, " hi"}, {32'd0, hi}, {32'd0, eh});
    chk({tag, " lo"}, {32'd0, lo}, {32'd0, el});
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
    start_op(o, a, b);
    wait_done(tag, 33, eh, el);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int pulses;
    rst = 1'b1; start = 1'b0; op = 3'b000; rs_val = '0; rt_val = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset hi", {32'd0, hi}, 64'd0);
    chk("reset lo", {32'd0, lo}, 64'd0);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);

    // MTHI / MTLO
    start_op(3'b100, 32'h1234_5678, 32'h0);
    chk("mthi hi", {32'd0, hi}, 64'h1234_5678);
    chk("mthi lo", {32'd0, lo}, 64'd0);
    chk("mthi busy", {63'd0, busy}, 64'd0);
    chk("mthi done", {63'd0, done}, 64'd0);
    start_op(3'b101, 32'h9ABC_DEF0, 32'h0);
    chk("mtlo hi", {32'd0, hi}, 64'h1234_5678);
    chk("mtlo lo", {32'd0, lo}, 64'h9ABC_DEF0);
    chk("mtlo busy", {63'd0, busy}, 64'd0);
    chk("mtlo done", {63'd0, done}, 64'd0);

    // no-op encodings
    start_op(3'b110, 32'hDEAD_BEEF, 32'h3);
    start_op(3'b111, 32'hCAFE_F00D, 32'h5);
    @(negedge clk);
    chk("noop hi", {32'd0, hi}, 64'h1234_5678);
    chk("noop lo", {32'd0, lo}, 64'h9ABC_DEF0);
    chk("noop busy", {63'd0, busy}, 64'd0);
    chk("noop done", {63'd0, done}, 64'd0);

    run_op("multu max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult -3*7", 3'b000, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div -7/2", 3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div min/-1", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("div 7/-2", 3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("div -5/0", 3'b010, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("divu ffffffff/16", 3'b011, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF);
    run_op("mult min*min", 3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("mult 5*-6", 3'b000, 32'h0000_0005, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFE2);

    // divide by zero followed by a request issued in the done cycle
    start_op(3'b011, 32'd100, 32'd0);
    wait_done("divu 100/0", 33, 32'h0000_0064, 32'hFFFF_FFFF);
    start_op(3'b001, 32'h0001_0000, 32'h0001_0000);
    chk("b2b busy", {63'd0, busy}, 64'd1);
    wait_done("b2b multu", 33, 32'h0000_0001, 32'h0000_0000);
    @(negedge clk);

    // request while busy is ignored; operands wiggle mid-operation
    start_op(3'b001, 32'd5, 32'd6);
    repeat (8) @(negedge clk);
    start_op(3'b011, 32'd9, 32'd3);
    wait_done("ignored start", 24, 32'd0, 32'd30);
    @(negedge clk);
    chk("ignored no 2nd done", {63'd0, done}, 64'd0);
    chk("ignored idle", {63'd0, busy}, 64'd0);

    run_op("mult -3*7 again", 3'b000, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    // reset mid-division aborts with no later done
    start_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0002);
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", {63'd0, busy}, 64'd0);
    chk("abort hi", {32'd0, hi}, 64'd0);
    chk("abort lo", {32'd0, lo}, 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || busy === 1'b1) pulses++;
      @(negedge clk);
    end
    chk("abort no done", 64'(pulses), 64'd0);

    // reset wins over a simultaneous request
    rst = 1'b1; start = 1'b1; op = 3'b100; rs_val = 32'h7777_7777;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; op = 3'b111;
    chk("rst prio hi", {32'd0, hi}, 64'd0);
    chk("rst prio busy", {63'd0, busy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WSIZE, default 32, operand/result width; all arithmetic rules below are stated for WSIZE=32.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
REQ-006 SHALL have port rs_val  input  WSIZE  operand A (multiplicand/dividend/MTHI-MTLO source).
REQ-007 SHALL have port rt_val  input  WSIZE  operand B (multiplier/divisor).
REQ-008 SHALL have port hi  output  WSIZE  HI register, feeds the writeback multiplexer.
REQ-009 SHALL have port lo  output  WSIZE  LO register, feeds the writeback multiplexer.
REQ-010 SHALL have port busy  output  1  high while an operation is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when hi/lo receive a MULT/DIV result.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FINISH; only those three.
REQ-013 SHALL, in IDLE with start=1 and op in {000..011}, latch operands and op, load iteration counter to 0, and enter CALC at that edge (edge E0).
REQ-014 SHALL execute one shift-add (multiply) or restoring shift-subtract (divide) step per cycle in CALC, for exactly 32 cycles (edges E1..E32), then enter FINISH.
REQ-015 SHALL, at edge E33 (leaving FINISH), write hi/lo, return to IDLE, and drive done=1 for exactly the following cycle.
REQ-016 SHALL drive busy=1 for the cycles following E0 through E32 (33 cycles) and busy=0 in the cycle done=1.
REQ-017 SHALL hold hi/lo unchanged from E0 through E32; intermediate values never visible on hi/lo.
REQ-018 SHALL ignore start (any op) while busy=1; no latching, no effect on the running operation.
REQ-019 SHALL, for MTHI/MTLO with start=1 in IDLE, copy rs_val to hi (resp. lo) at that edge, stay in IDLE, assert neither busy nor done.
REQ-020 SHALL treat op 110/111 with start=1 as no-op: state, hi, lo unchanged, done stays 0.
REQ-021 MULTU SHALL produce {hi,lo} = unsigned 64-bit product of rs_val*rt_val.
REQ-022 MULT SHALL produce {hi,lo} = two's-complement 64-bit product, computed on magnitudes and negated in FINISH when operand signs differ.
REQ-023 DIVU SHALL produce lo = unsigned quotient, hi = unsigned remainder.
REQ-024 DIV SHALL produce quotient truncated toward zero in lo, remainder with sign of dividend in hi.
REQ-025 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000, no exception.
REQ-026 Division by zero (DIV or DIVU) SHALL run the full 33-cycle latency and give lo=0xFFFFFFFF, hi=rs_val as latched.
REQ-027 SHALL sample operands only at E0; changes to rs_val/rt_val/op afterwards have no effect.
REQ-028 A new start SHALL be accepted in the same cycle done=1 (FSM already IDLE); its result appears 33 edges later.

Reset
REQ-029 SHALL, when rst=1 at a rising edge, set state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, regardless of state or start.
REQ-030 Reset mid-operation SHALL abort it with no later done pulse; rst has priority over start at the same edge.

Verification
REQ-031 MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 33 busy cycles done pulse, hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 MULT rs=0xFFFFFFFD (-3), rt=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV rs=-7 (0xFFFFFFF9), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-033 DIVU rs=100, rt=0 -> lo=0xFFFFFFFF, hi=0x00000064; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 Start MULTU 5*6, reassert start with DIVU 9/3 at cycle 10 -> second request ignored, hi=0, lo=30 at done; back-to-back start during done cycle -> accepted, second done 33 cycles later.
REQ-035 Start DIV, assert rst at cycle 15 -> next cycle busy=0, hi=lo=0, no done pulse within 40 cycles.
REQ-036 MTHI rs=0x12345678 then MTLO rs=0x9ABCDEF0 in IDLE -> hi/lo updated next cycle, busy=0, done=0 throughout.
